// File: rtl/dflow_tuple_replay_engine_if.sv
// Tuple stream bundle for the replay engine: capture-side input stream and replay-side output stream.
// The engine connects through the slave modport; the environment driving it uses master.
interface dflow_tuple_replay_engine_if #(
  parameter int PKT_TUPLE_WIDTH = 104,
  parameter int PKT_LEN_WIDTH   = 16,
  parameter int CH_WIDTH        = 2
);
  logic [PKT_TUPLE_WIDTH-1:0] tuple_in_data;
  logic [PKT_LEN_WIDTH-1:0]   tuple_in_len;
  logic                       tuple_in_vld;
  logic                       tuple_in_ready;
  logic [PKT_TUPLE_WIDTH-1:0] tuple_out_data;
  logic [PKT_LEN_WIDTH-1:0]   tuple_out_len;
  logic [CH_WIDTH-1:0]        tuple_out_ch;
  logic                       tuple_out_vld;
  logic                       tuple_out_ready;

  modport slave (
    input  tuple_in_data, tuple_in_len, tuple_in_vld, tuple_out_ready,
    output tuple_in_ready, tuple_out_data, tuple_out_len, tuple_out_ch, tuple_out_vld
  );

  modport master (
    output tuple_in_data, tuple_in_len, tuple_in_vld, tuple_out_ready,
    input  tuple_in_ready, tuple_out_data, tuple_out_len, tuple_out_ch, tuple_out_vld
  );
endinterface

// File: rtl/dflow_tuple_replay_engine.sv
// Captures 5-tuple + length records into on-chip RAM and replays them N times (or until stopped),
// spreading them round-robin over NUM_CH channels with a programmable inter-record gap.
module dflow_tuple_replay_engine #(
  parameter int PKT_TUPLE_WIDTH = 104,
  parameter int PKT_LEN_WIDTH   = 16,
  parameter int MEM_DEPTH       = 1024,
  parameter int ADDR_WIDTH      = 10,
  parameter int NUM_CH          = 4,
  parameter int CH_WIDTH        = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      sw_rst,
  input  logic                      start_store,
  input  logic                      start_replay,
  input  logic                      stop,
  input  logic [15:0]               repeat_cnt,
  input  logic [15:0]               gap_cycles,
  dflow_tuple_replay_engine_if.slave bus,
  output logic [ADDR_WIDTH:0]       store_count,
  output logic                      complete_store,
  output logic                      complete_replay,
  output logic                      busy,
  output logic [31:0]               pkt_sent_count
);

  localparam int WORD_WIDTH = PKT_TUPLE_WIDTH + PKT_LEN_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_FULL = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] COUNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [CH_WIDTH-1:0] LAST_CH    = CH_WIDTH'(NUM_CH - 1);

  typedef enum logic [2:0] {IDLE, STORE, RD, OUT, GAP, DONE} state_t;

  state_t state, next_state;

  logic [WORD_WIDTH-1:0] mem [MEM_DEPTH];
  logic [WORD_WIDTH-1:0] rd_word;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [15:0]           pass_cnt;
  logic [15:0]           pass_next;
  logic [15:0]           repeat_q;
  logic [15:0]           gap_q;
  logic [15:0]           gap_cnt;
  logic [CH_WIDTH-1:0]   ch_q;
  logic                  stop_seen;

  logic idle_like;
  logic store_go;
  logic replay_go;
  logic in_ready;
  logic in_beat;
  logic out_hs;
  logic last_rec;
  logic stop_any;
  logic repeat_done;
  logic replaying;

  assign idle_like   = (state == IDLE) || (state == DONE);
  assign store_go    = idle_like && start_store;
  assign replay_go   = idle_like && start_replay && !start_store;
  assign in_beat     = in_ready && bus.tuple_in_vld;
  assign out_hs      = (state == OUT) && bus.tuple_out_ready;
  assign last_rec    = ({1'b0, rd_ptr} + COUNT_ONE) == store_count;
  assign pass_next   = last_rec ? pass_cnt + 16'd1 : pass_cnt;
  assign stop_any    = stop || stop_seen;
  assign repeat_done = (repeat_q != 16'd0) && (pass_next == repeat_q);
  assign replaying   = (state == RD) || (state == OUT) || (state == GAP);

  assign bus.tuple_in_ready = in_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else if (sw_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A stop that arrives while a record is presented is only honoured once that record is taken.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, DONE: begin
        if (start_store) begin
          next_state = STORE;
        end else if (start_replay) begin
          next_state = (store_count == '0) ? DONE : RD;
        end else if (state == DONE) begin
          next_state = IDLE;
        end
      end
      STORE: begin
        if (stop || (in_beat && (store_count == DEPTH_FULL - COUNT_ONE))) begin
          next_state = DONE;
        end
      end
      RD: begin
        next_state = stop_any ? DONE : OUT;
      end
      OUT: begin
        if (bus.tuple_out_ready) begin
          if (stop_any || repeat_done) begin
            next_state = DONE;
          end else if (gap_q != 16'd0) begin
            next_state = GAP;
          end else begin
            next_state = RD;
          end
        end
      end
      GAP: begin
        if (stop_any) begin
          next_state = DONE;
        end else if (gap_cnt == 16'd0) begin
          next_state = RD;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready           = 1'b0;
    busy               = !idle_like;
    bus.tuple_out_vld  = 1'b0;
    bus.tuple_out_data = '0;
    bus.tuple_out_len  = '0;
    bus.tuple_out_ch   = '0;
    unique case (state)
      STORE: in_ready = store_count < DEPTH_FULL;
      OUT: begin
        bus.tuple_out_vld  = 1'b1;
        bus.tuple_out_data = rd_word[WORD_WIDTH-1:PKT_LEN_WIDTH];
        bus.tuple_out_len  = rd_word[PKT_LEN_WIDTH-1:0];
        bus.tuple_out_ch   = ch_q;
      end
      default: ;
    endcase
  end

  // Record store: no reset so contents survive both resets; rd_word is only refreshed from RD.
  always_ff @(posedge clk) begin
    if (in_beat) begin
      mem[store_count[ADDR_WIDTH-1:0]] <= {bus.tuple_in_data, bus.tuple_in_len};
    end
    if (state == RD) begin
      rd_word <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      store_count     <= '0;
      complete_store  <= 1'b0;
      complete_replay <= 1'b0;
      pkt_sent_count  <= '0;
      rd_ptr          <= '0;
      pass_cnt        <= '0;
      repeat_q        <= '0;
      gap_q           <= '0;
      gap_cnt         <= '0;
      ch_q            <= '0;
      stop_seen       <= 1'b0;
    end else if (sw_rst) begin
      store_count     <= '0;
      complete_store  <= 1'b0;
      complete_replay <= 1'b0;
      pkt_sent_count  <= '0;
      rd_ptr          <= '0;
      pass_cnt        <= '0;
      repeat_q        <= '0;
      gap_q           <= '0;
      gap_cnt         <= '0;
      ch_q            <= '0;
      stop_seen       <= 1'b0;
    end else begin
      if (store_go) begin
        store_count    <= '0;
        complete_store <= 1'b0;
      end else if (in_beat) begin
        store_count <= store_count + COUNT_ONE;
      end
      if ((state == STORE) && (next_state == DONE)) begin
        complete_store <= 1'b1;
      end

      // Replay knobs are frozen here so later register writes cannot disturb a running replay.
      if (replay_go) begin
        rd_ptr          <= '0;
        pass_cnt        <= '0;
        ch_q            <= '0;
        pkt_sent_count  <= '0;
        complete_replay <= 1'b0;
        stop_seen       <= 1'b0;
        repeat_q        <= repeat_cnt;
        gap_q           <= gap_cycles;
      end

      if (replaying && stop) begin
        stop_seen <= 1'b1;
      end

      if (out_hs) begin
        pkt_sent_count <= pkt_sent_count + 32'd1;
        ch_q           <= (ch_q == LAST_CH) ? '0 : ch_q + CH_WIDTH'(1);
        rd_ptr         <= last_rec ? '0 : rd_ptr + ADDR_WIDTH'(1);
        pass_cnt       <= pass_next;
        gap_cnt        <= gap_q - 16'd1;
      end else if ((state == GAP) && (gap_cnt != 16'd0)) begin
        gap_cnt <= gap_cnt - 16'd1;
      end

      if ((replaying && (next_state == DONE)) || (replay_go && (store_count == '0))) begin
        complete_replay <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dflow_tuple_replay_engine.sv
// Directed-sequence bench for dflow_tuple_replay_engine with random record contents; expected
// replay output comes from an array model of stored records indexed by output number.
module tb_dflow_tuple_replay_engine;

  localparam int TW    = 104;
  localparam int LW    = 16;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int NCH   = 4;
  localparam int CW    = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          sw_rst = 1'b0;
  logic          start_store = 1'b0;
  logic          start_replay = 1'b0;
  logic          stop = 1'b0;
  logic [15:0]   repeat_cnt = '0;
  logic [15:0]   gap_cycles = '0;
  logic [AW:0]   store_count;
  logic          complete_store;
  logic          complete_replay;
  logic          busy;
  logic [31:0]   pkt_sent_count;

  dflow_tuple_replay_engine_if #(.PKT_TUPLE_WIDTH(TW), .PKT_LEN_WIDTH(LW), .CH_WIDTH(CW)) bus ();

  dflow_tuple_replay_engine #(
    .PKT_TUPLE_WIDTH(TW), .PKT_LEN_WIDTH(LW), .MEM_DEPTH(DEPTH),
    .ADDR_WIDTH(AW), .NUM_CH(NCH), .CH_WIDTH(CW)
  ) dut (
    .clk(clk), .resetn(resetn), .sw_rst(sw_rst),
    .start_store(start_store), .start_replay(start_replay), .stop(stop),
    .repeat_cnt(repeat_cnt), .gap_cycles(gap_cycles), .bus(bus),
    .store_count(store_count), .complete_store(complete_store),
    .complete_replay(complete_replay), .busy(busy), .pkt_sent_count(pkt_sent_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference store: what the engine should hold, in arrival order.
  logic [TW-1:0] m_tuple [DEPTH];
  logic [LW-1:0] m_len   [DEPTH];
  int            m_count = 0;

  // Observed output stream.
  logic [TW-1:0] hs_data [$];
  logic [LW-1:0] hs_len  [$];
  logic [CW-1:0] hs_ch   [$];
  int            hs_cyc  [$];
  int            rise_cyc[$];
  int            stall_err = 0;
  logic          prev_vld = 1'b0;
  logic          held = 1'b0;
  logic [TW-1:0] pd = '0;
  logic [LW-1:0] pl = '0;
  logic [CW-1:0] pc = '0;

  always @(negedge clk) begin
    if (bus.tuple_out_vld) begin
      if (!prev_vld) rise_cyc.push_back(cyc);
      else if (held && (bus.tuple_out_data !== pd || bus.tuple_out_len !== pl || bus.tuple_out_ch !== pc))
        stall_err++;
      pd = bus.tuple_out_data;
      pl = bus.tuple_out_len;
      pc = bus.tuple_out_ch;
      if (bus.tuple_out_ready) begin
        hs_data.push_back(bus.tuple_out_data);
        hs_len.push_back(bus.tuple_out_len);
        hs_ch.push_back(bus.tuple_out_ch);
        hs_cyc.push_back(cyc);
        held = 1'b0;
      end else begin
        held = 1'b1;
      end
    end else begin
      held = 1'b0;
    end
    prev_vld = bus.tuple_out_vld;
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    n_tests++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic clear_mon();
    hs_data.delete();
    hs_len.delete();
    hs_ch.delete();
    hs_cyc.delete();
    rise_cyc.delete();
    stall_err = 0;
  endtask

  // Capture session: start_store, offer n beats, optionally raise stop together with the last beat.
  task automatic applyStimulus(input int n, input bit stop_last, input int len_base,
                               output int accepted, output int refused);
    logic [127:0] r;
    accepted = 0;
    refused  = 0;
    @(posedge clk); #1 start_store = 1'b1;
    @(posedge clk); #1 start_store = 1'b0;
    for (int i = 0; i < n; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.tuple_in_data = r[TW-1:0];
      bus.tuple_in_len  = (len_base >= 0) ? LW'(len_base + i) : LW'($urandom());
      bus.tuple_in_vld  = 1'b1;
      stop = stop_last && (i == n - 1);
      @(negedge clk);
      if (bus.tuple_in_ready) begin
        if (accepted < DEPTH) begin
          m_tuple[accepted] = bus.tuple_in_data;
          m_len[accepted]   = bus.tuple_in_len;
        end
        accepted++;
      end else begin
        refused++;
      end
      @(posedge clk); #1;
    end
    bus.tuple_in_vld = 1'b0;
    stop = 1'b0;
    m_count = (accepted > DEPTH) ? DEPTH : accepted;
  endtask

  task automatic start_replay_cmd(input logic [15:0] rep, input logic [15:0] gap);
    repeat_cnt = rep;
    gap_cycles = gap;
    clear_mon();
    @(posedge clk); #1 start_replay = 1'b1;
  endtask

  // Drives ready (optionally held low for the first two cycles of each record) until the replay ends.
  task automatic run_replay(input bit throttle, input int stop_after, input int budget);
    int  age = 0;
    bit  done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        start_replay = 1'b0;
        repeat_cnt   = 16'($urandom_range(1, 3));
        gap_cycles   = 16'($urandom_range(5, 9));
      end
      stop = 1'b0;
      if (bus.tuple_out_vld) age++;
      else age = 0;
      bus.tuple_out_ready = throttle ? (age > 2) : 1'b1;
      if (stop_after >= 0 && bus.tuple_out_vld && age == 1 && hs_data.size() == stop_after)
        stop = 1'b1;
      if (complete_replay && !busy) done = 1'b1;
    end
    stop = 1'b0;
    bus.tuple_out_ready = 1'b0;
    checkOutput("replay_finished_in_budget", 128'(done), 128'(1));
  endtask

  task automatic check_replay(input string tag, input int k, input int gap);
    checkOutput({tag, "_count"}, 128'(hs_data.size()), 128'(k));
    checkOutput({tag, "_vld_rises"}, 128'(rise_cyc.size()), 128'(k));
    checkOutput({tag, "_stall_hold"}, 128'(stall_err), 128'(0));
    for (int j = 0; j < k && j < hs_data.size(); j++) begin
      checkOutput($sformatf("%s_data[%0d]", tag, j), 128'(hs_data[j]), 128'(m_tuple[j % m_count]));
      checkOutput($sformatf("%s_len[%0d]", tag, j), 128'(hs_len[j]), 128'(m_len[j % m_count]));
      checkOutput($sformatf("%s_ch[%0d]", tag, j), 128'(hs_ch[j]), 128'(j % NCH));
      if (j > 0 && j < rise_cyc.size())
        checkOutput($sformatf("%s_idle[%0d]", tag, j), 128'(rise_cyc[j] - hs_cyc[j-1] - 1), 128'(gap + 1));
    end
  endtask

  initial begin
    int acc;
    int refused;
    bus.tuple_in_data   = '0;
    bus.tuple_in_len    = '0;
    bus.tuple_in_vld    = 1'b0;
    bus.tuple_out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_store_count", 128'(store_count), 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_in_ready", 128'(bus.tuple_in_ready), 128'(0));
    checkOutput("rst_out_vld", 128'(bus.tuple_out_vld), 128'(0));
    checkOutput("rst_pkt_sent", 128'(pkt_sent_count), 128'(0));
    checkOutput("rst_complete", 128'({complete_store, complete_replay}), 128'(0));
    resetn = 1'b1;

    // Five records, stop raised together with the fifth beat.
    applyStimulus(5, 1'b1, 64, acc, refused);
    checkOutput("t1_accepted", 128'(acc), 128'(5));
    checkOutput("t1_store_count", 128'(store_count), 128'(5));
    checkOutput("t1_complete_store", 128'(complete_store), 128'(1));
    checkOutput("t1_in_ready_after", 128'(bus.tuple_in_ready), 128'(0));
    checkOutput("t1_busy_after", 128'(busy), 128'(0));

    start_replay_cmd(16'd2, 16'd0);
    run_replay(1'b0, -1, 200);
    check_replay("t2", 10, 0);
    checkOutput("t2_pkt_sent", 128'(pkt_sent_count), 128'(10));
    checkOutput("t2_complete_replay", 128'(complete_replay), 128'(1));

    start_replay_cmd(16'd2, 16'd3);
    run_replay(1'b1, -1, 400);
    check_replay("t3", 10, 3);
    checkOutput("t3_pkt_sent", 128'(pkt_sent_count), 128'(10));

    applyStimulus(DEPTH + 3, 1'b0, -1, acc, refused);
    checkOutput("t4_accepted", 128'(acc), 128'(DEPTH));
    checkOutput("t4_refused", 128'(refused), 128'(3));
    checkOutput("t4_store_count", 128'(store_count), 128'(DEPTH));
    checkOutput("t4_complete_store", 128'(complete_store), 128'(1));

    // Endless replay; stop lands while the third record is stalled.
    applyStimulus(5, 1'b1, -1, acc, refused);
    start_replay_cmd(16'd0, 16'd0);
    run_replay(1'b1, 2, 300);
    repeat (10) @(posedge clk);
    #1;
    check_replay("t5", 3, 0);
    checkOutput("t5_pkt_sent", 128'(pkt_sent_count), 128'(3));
    checkOutput("t5_complete_replay", 128'(complete_replay), 128'(1));

    // Both starts together: capture wins; stop immediately leaves an empty store.
    clear_mon();
    @(posedge clk); #1 start_store = 1'b1; start_replay = 1'b1;
    @(posedge clk); #1 start_store = 1'b0; start_replay = 1'b0;
    checkOutput("t6_both_in_ready", 128'(bus.tuple_in_ready), 128'(1));
    checkOutput("t6_both_complete_store", 128'(complete_store), 128'(0));
    stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    checkOutput("t6_empty_store_count", 128'(store_count), 128'(0));
    checkOutput("t6_empty_complete_store", 128'(complete_store), 128'(1));
    checkOutput("t6_both_no_vld", 128'(rise_cyc.size()), 128'(0));
    m_count = 0;
    start_replay_cmd(16'd3, 16'd0);
    run_replay(1'b0, -1, 50);
    checkOutput("t6_empty_replay_vld", 128'(rise_cyc.size()), 128'(0));
    checkOutput("t6_empty_complete_replay", 128'(complete_replay), 128'(1));

    // Soft reset mid-replay, with a start_store in the same cycle that must be ignored.
    applyStimulus(3, 1'b1, 200, acc, refused);
    start_replay_cmd(16'd0, 16'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 start_replay = 1'b0; bus.tuple_out_ready = 1'b1;
    end
    checkOutput("t6_sw_progress", 128'(hs_data.size() > 0), 128'(1));
    sw_rst = 1'b1; start_store = 1'b1;
    @(posedge clk); #1 sw_rst = 1'b0; start_store = 1'b0; bus.tuple_out_ready = 1'b0;
    checkOutput("t6_sw_busy", 128'(busy), 128'(0));
    checkOutput("t6_sw_vld", 128'(bus.tuple_out_vld), 128'(0));
    checkOutput("t6_sw_in_ready", 128'(bus.tuple_in_ready), 128'(0));
    checkOutput("t6_sw_counts", 128'({store_count, pkt_sent_count}), 128'(0));

    // Hard reset mid-replay, then replay without storing again.
    applyStimulus(4, 1'b1, -1, acc, refused);
    start_replay_cmd(16'd0, 16'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 start_replay = 1'b0; bus.tuple_out_ready = 1'b1;
    end
    checkOutput("t6_rst_progress", 128'(pkt_sent_count > 0), 128'(1));
    #2 resetn = 1'b0;
    #1;
    checkOutput("t6_rst_vld", 128'(bus.tuple_out_vld), 128'(0));
    checkOutput("t6_rst_busy", 128'(busy), 128'(0));
    checkOutput("t6_rst_pkt_sent", 128'(pkt_sent_count), 128'(0));
    checkOutput("t6_rst_store_count", 128'(store_count), 128'(0));
    checkOutput("t6_rst_complete", 128'({complete_store, complete_replay}), 128'(0));
    bus.tuple_out_ready = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    m_count = 0;
    start_replay_cmd(16'd1, 16'd0);
    run_replay(1'b0, -1, 50);
    checkOutput("t6_post_rst_vld", 128'(rise_cyc.size()), 128'(0));
    checkOutput("t6_post_rst_complete_replay", 128'(complete_replay), 128'(1));
    checkOutput("t6_post_rst_pkt_sent", 128'(pkt_sent_count), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
